// File: rtl/vga_frame_reader.sv
`default_nettype none
// ============================================================================
// vga_frame_reader : raster timing, frame-RAM read addressing and pin realign
// Revision: 1.0
// ============================================================================
module vga_frame_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int COLOR_DEPTH = 8,
  parameter int ADDR_WIDTH  = 19,
  parameter int RD_LATENCY  = 2
) (
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic                       enable,
  output logic [ADDR_WIDTH-1:0]      rd_addr,
  output logic                       rd_en,
  input  logic [3*COLOR_DEPTH-1:0]   rd_data,
  output logic [COLOR_DEPTH-1:0]     vga_r,
  output logic [COLOR_DEPTH-1:0]     vga_g,
  output logic [COLOR_DEPTH-1:0]     vga_b,
  output logic                       vga_hs,
  output logic                       vga_vs,
  output logic                       vga_blank_n,
  output logic                       vga_sync_n,
  output logic                       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Delay-line word layout {frame_start, vs, hs, active}; idle = syncs high.
  localparam logic [3:0] DL_IDLE = 4'b0110;

  logic [H_W-1:0]               h_cnt_q, h_cnt_d;
  logic [V_W-1:0]               v_cnt_q, v_cnt_d;
  logic [ADDR_WIDTH-1:0]        pix_addr_q, pix_addr_d;
  logic [3:0]                   dl_q [RD_LATENCY];
  logic [3:0]                   dl_d [RD_LATENCY];
  logic [3*COLOR_DEPTH-1:0]     rgb_q, rgb_d;
  logic                         hs_q, hs_d;
  logic                         vs_q, vs_d;
  logic                         blank_n_q, blank_n_d;
  logic                         fs_q, fs_d;

  logic                         active0;
  logic                         hs0;
  logic                         vs0;
  logic                         fs0;
  logic                         h_wrap;
  logic                         frame_end;

  always_comb begin
    h_wrap    = (h_cnt_q == H_LAST);
    frame_end = h_wrap && (v_cnt_q == V_LAST);
    active0   = enable && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs0       = ~(enable && (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    vs0       = ~(enable && (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    fs0       = enable && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + V_W'(1);
    end else begin
      h_cnt_d = h_cnt_q + H_W'(1);
    end
  end

  // Linear address advances only on visible pixels, so it equals v*H_ACTIVE+h.
  always_comb begin
    pix_addr_d = pix_addr_q;
    if (!enable || frame_end) begin
      pix_addr_d = '0;
    end else if (active0) begin
      pix_addr_d = pix_addr_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    dl_d[0] = {fs0, vs0, hs0, active0};
    for (int i = 1; i < RD_LATENCY; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  always_comb begin
    rgb_d     = dl_q[RD_LATENCY-1][0] ? rd_data : '0;
    blank_n_d = dl_q[RD_LATENCY-1][0];
    hs_d      = dl_q[RD_LATENCY-1][1];
    vs_d      = dl_q[RD_LATENCY-1][2];
    fs_d      = dl_q[RD_LATENCY-1][3];
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      pix_addr_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dl_q[i] <= DL_IDLE;
      end
      rgb_q      <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      pix_addr_q <= pix_addr_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dl_q[i] <= dl_d[i];
      end
      rgb_q      <= rgb_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_n_q  <= blank_n_d;
      fs_q       <= fs_d;
    end
  end

  assign rd_addr     = pix_addr_q;
  assign rd_en       = active0 & ~reset;
  assign vga_r       = rgb_q[3*COLOR_DEPTH-1:2*COLOR_DEPTH];
  assign vga_g       = rgb_q[2*COLOR_DEPTH-1:COLOR_DEPTH];
  assign vga_b       = rgb_q[COLOR_DEPTH-1:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_reader.sv
`default_nettype none
// ============================================================================
// tb_vga_frame_reader : randomized enable/reset stimulus against a frame model
// Revision: 1.0
// ============================================================================
module tb_vga_frame_reader;

  // Reduced raster so several whole frames fit in a short run.
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int CD = 8, AW = 19, RL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  localparam logic [28:0] IDLE = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0};

  logic          vga_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          enable  = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [23:0]   rd_data = 24'd0;
  logic [23:0]   ram_p1  = 24'd0;
  logic [CD-1:0] vga_r, vga_g, vga_b;
  logic          vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

  logic [23:0]   key    = 24'hFF0000;
  logic          run    = 1'b1;
  logic          cnt_on = 1'b0;
  int            rd_cnt = 0;
  int            p      = 0;
  logic [28:0]   hist [RL+1];
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 vga_clk = ~vga_clk;

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_DEPTH(CD), .ADDR_WIDTH(AW), .RD_LATENCY(RL)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .enable(enable),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .frame_start(frame_start)
  );

  // Two-cycle RAM returning key ^ address.
  always @(posedge vga_clk) begin
    ram_p1  <= key ^ 24'(rd_addr);
    rd_data <= ram_p1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Expected pin word {hs, vs, blank_n, frame_start, sync_n, rgb} for raster position pos.
  function automatic logic [28:0] exp_tuple(input logic en, input int pos, input logic [23:0] k);
    int   h, v;
    logic act;
    h   = pos % HT;
    v   = pos / HT;
    act = en && (h < HA) && (v < VA);
    return {~(en && h >= HA + HF && h < HA + HF + HS),
            ~(en && v >= VA + VF && v < VA + VF + VS),
            act, en && h == 0 && v == 0, 1'b0,
            act ? (k ^ 24'(v * HA + h)) : 24'd0};
  endfunction

  // Raster position: frame-flat pixel index since the last enable/reset.
  always @(posedge vga_clk) begin
    if (reset || !enable) p = 0;
    else p = (p + 1) % FT;
  end

  always @(negedge vga_clk) begin
    if (run) begin
      int          pe, h, v;
      logic        exp_en;
      logic [28:0] cur, obs;
      pe     = reset ? 0 : p;
      h      = pe % HT;
      v      = pe / HT;
      exp_en = !reset && enable && (h < HA) && (v < VA);
      cur    = reset ? IDLE : exp_tuple(enable, pe, key);
      if (reset) for (int i = 0; i <= RL; i++) hist[i] = IDLE;
      obs = {vga_hs, vga_vs, vga_blank_n, frame_start, vga_sync_n, vga_r, vga_g, vga_b};
      check_eq("pins", 64'(obs), 64'(hist[RL]));
      check_eq("rd", 64'({rd_en, exp_en ? rd_addr : AW'(0)}),
                     64'({exp_en, exp_en ? AW'(v * HA + h) : AW'(0)}));
      for (int i = RL; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = cur;
      if (cnt_on && rd_en) rd_cnt++;
    end
  end

  initial begin
    repeat (5) @(posedge vga_clk);
    #2 reset = 1'b0;
    repeat (60) begin
      @(negedge vga_clk);
      check_eq("idle_addr", 64'(rd_addr), 64'd0);
    end

    // Three uninterrupted frames with the red marker at address 0.
    @(posedge vga_clk);
    #2 enable = 1'b1;
    cnt_on = 1'b1;
    repeat (3 * FT) @(negedge vga_clk);
    #1 cnt_on = 1'b0;
    check_eq("rd_en_count", 64'(rd_cnt), 64'(3 * HA * VA));

    // Drop enable mid-line, then resume from the frame origin.
    repeat (3 * HT + 10) @(posedge vga_clk);
    #2 enable = 1'b0;
    repeat (7) @(posedge vga_clk);
    #2 enable = 1'b1;
    repeat (FT + 20) @(posedge vga_clk);

    for (int it = 0; it < 40; it++) begin
      int r;
      @(posedge vga_clk);
      #2;
      r   = int'($urandom_range(0, 9));
      key = 24'($urandom);
      if (r == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(2, 5)) @(posedge vga_clk);
        #2 reset = 1'b0;
      end else if (r < 3) begin
        enable = 1'b0;
      end else begin
        enable = 1'b1;
      end
      repeat ($urandom_range(1, 2 * FT)) @(posedge vga_clk);
    end

    @(posedge vga_clk);
    #2 enable = 1'b1;
    repeat (FT + 10) @(posedge vga_clk);
    #1 run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
Scan-out side of the VGA frame buffer. Generates 640x480@60 raster timing on vga_clk, issues linear read addresses to the read port of the 2-port frame RAM, and realigns the returned 24-bit RGB data with delayed sync/blank to drive the VGA DAC pins. Sits between the RAM read port (outclock domain) and the board VGA connector. The write side fills the same RAM from sys_clk.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
COLOR_DEPTH, 8, bits per colour channel
ADDR_WIDTH, 19, RAM address width
RD_LATENCY, 2, RAM read latency in vga_clk cycles (>=1)

Ports:
vga_clk  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = scan out; 0 = hold raster at frame start, outputs blanked
rd_addr  out  ADDR_WIDTH  RAM read address
rd_en  out  1  RAM read enable, high for active pixels
rd_data  in  3*COLOR_DEPTH  RAM read data {R,G,B}, valid RD_LATENCY cycles after rd_addr
vga_r  out  COLOR_DEPTH  red
vga_g  out  COLOR_DEPTH  green
vga_b  out  COLOR_DEPTH  blue
vga_hs  out  1  horizontal sync, active low
vga_vs  out  1  vertical sync, active low
vga_blank_n  out  1  low during blanking
vga_sync_n  out  1  tied 0 (no sync-on-green)
frame_start  out  1  one-cycle pulse at pins with pixel (0,0)

Behaviour:
- Interface fixed: single clock vga_clk; reset asynchronous, active-high.
- H_TOTAL = sum of H params = 800; V_TOTAL = 525.
- Stage 0 (counters): h_cnt 0..H_TOTAL-1, wraps to 0; v_cnt increments on h wrap, wraps 0 after V_TOTAL-1. enable=0 holds both at 0.
- active0 = enable & (h_cnt<H_ACTIVE) & (v_cnt<V_ACTIVE).
- hs0 low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751; vs0 low for v_cnt in [490, 491]; both forced high when enable=0.
- pix_addr register: cleared to 0 when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, or when enable=0; else +1 each cycle active0=1. No multiplier. rd_addr = pix_addr, so rd_addr = v*640+h during active pixel (h,v); range 0..307199; holds value through blanking. rd_en = active0.
- Delay line: active0, hs0, vs0, fs0 (= enable & h_cnt=0 & v_cnt=0) delayed RD_LATENCY cycles.
- Output stage registered: vga_hs/vs/blank_n/frame_start <= delayed values; {vga_r,vga_g,vga_b} <= delayed active ? rd_data : 0.
- Total latency counters -> pins = RD_LATENCY+1 cycles for all pin signals; colour and syncs always mutually aligned.
- Reset: h_cnt, v_cnt, pix_addr = 0; delay lines cleared (active 0, syncs 1); rd_en 0; vga_r/g/b 0; vga_hs 1; vga_vs 1; vga_blank_n 0; frame_start 0; vga_sync_n 0.
- enable falling mid-frame: counters go to 0 next cycle; pins blank/syncs inactive RD_LATENCY+1 cycles later; no partial frame resumed.
- enable rising: raster starts at (0,0); frame_start pulses RD_LATENCY+1 cycles later.
- Reset mid-frame: immediate async return to reset values; restart from (0,0) after release.
- rd_data ignored outside delayed active window.

Test Plan:
- Reset asserted then released with enable=0 -> all pins at reset values, rd_en=0, rd_addr=0 for 1000 cycles.
- enable=1, RAM model latency 2 returning 24'hFF0000 for addr 0 -> frame_start and vga_r=8'hFF, vga_g=vga_b=0, vga_blank_n=1 exactly 3 cycles after rd_addr=0 issued.
- Line timing -> vga_hs low 96 cycles, period 800; vga_blank_n high 640 cycles per visible line; rgb 0 whenever blank_n=0.
- Frame timing -> vga_vs low 2 lines (1600 cycles), period 420000 cycles; rd_addr reaches 307199 on last pixel, then 0 at next frame; 307200 rd_en cycles per frame.
- Address pattern: RAM data = address -> pin colour equals v*640+h for sampled pixels (0,0), (639,0), (0,1), (639,479).
- enable dropped at h=300,v=100 then raised -> blank within 3 cycles, next frame_start after re-enable, rd_addr restarts at 0; async reset mid-line gives the same restart.
